// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one classic Wishbone slave port among up to four
// masters, with a bus watchdog that aborts cycles a slave never answers.
module wb_rr_arbiter #(
  parameter int unsigned NMASTERS = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NMASTERS-1:0]    m_cyc_i,
  input  logic [NMASTERS-1:0]    m_stb_i,
  input  logic [NMASTERS-1:0]    m_we_i,
  input  logic [4*NMASTERS-1:0]  m_sel_i,
  input  logic [36*NMASTERS-1:0] m_adr_i,
  input  logic [32*NMASTERS-1:0] m_dat_i,
  output logic [31:0]            m_dat_o,
  output logic [NMASTERS-1:0]    m_ack_o,
  output logic [NMASTERS-1:0]    m_err_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [3:0]             s_sel_o,
  output logic [35:0]            s_adr_o,
  output logic [31:0]            s_dat_o,
  input  logic [31:0]            s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [NMASTERS-1:0]    gnt_o
);

  localparam int unsigned AW = 36;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned IW = (NMASTERS > 2) ? 2 : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_ABORT = 3'b100
  } state_t;

  state_t            state;
  logic [IW-1:0]     last;
  logic [CW-1:0]     wd_cnt;
  logic              to_pulse;

  logic              win_valid;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [NMASTERS-1:0] win_gnt;

  logic              mux_cyc;
  logic              mux_stb;
  logic              mux_we;
  logic [SW-1:0]     mux_sel;
  logic [AW-1:0]     mux_adr;
  logic [DW-1:0]     mux_dat;

  logic              in_grant;
  logic              slv_resp;
  logic              wd_fire;

  // Round-robin search starting just above the last granted master; scanning
  // the ring backwards lets the closest requester overwrite earlier hits.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = last;
    cand      = last;
    for (int unsigned i = NMASTERS; i >= 1; i--) begin
      cand = IW'((32'(last) + i) % NMASTERS);
      if (m_cyc_i[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_gnt = NMASTERS'(1) << win_idx;

  // AND-OR mux of the granted master's signals; all zero when nothing is granted.
  always_comb begin
    mux_cyc = 1'b0;
    mux_stb = 1'b0;
    mux_we  = 1'b0;
    mux_sel = '0;
    mux_adr = '0;
    mux_dat = '0;
    for (int unsigned k = 0; k < NMASTERS; k++) begin
      mux_cyc = mux_cyc | (m_cyc_i[k] & gnt_o[k]);
      mux_stb = mux_stb | (m_stb_i[k] & gnt_o[k]);
      mux_we  = mux_we  | (m_we_i[k]  & gnt_o[k]);
      mux_sel = mux_sel | (m_sel_i[k*SW +: SW] & {SW{gnt_o[k]}});
      mux_adr = mux_adr | (m_adr_i[k*AW +: AW] & {AW{gnt_o[k]}});
      mux_dat = mux_dat | (m_dat_i[k*DW +: DW] & {DW{gnt_o[k]}});
    end
  end

  assign in_grant = (state == ST_GRANT);
  assign slv_resp = s_ack_i | s_err_i;

  assign s_cyc_o  = mux_cyc & in_grant;
  assign s_stb_o  = mux_stb & in_grant;
  assign s_we_o   = mux_we;
  assign s_sel_o  = mux_sel;
  assign s_adr_o  = mux_adr;
  assign s_dat_o  = mux_dat;

  assign m_dat_o  = s_dat_i;
  assign m_ack_o  = {NMASTERS{s_ack_i & in_grant}} & gnt_o;
  assign m_err_o  = ({NMASTERS{s_err_i & in_grant}} | {NMASTERS{to_pulse}}) & gnt_o;

  // A response in the terminal count cycle beats the watchdog.
  assign wd_fire  = in_grant & s_stb_o & ~slv_resp & (wd_cnt == CW'(TIMEOUT - 1));

  // Arbitration FSM: grant, release on cyc drop, abort on watchdog expiry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      gnt_o    <= '0;
      last     <= IW'(NMASTERS - 1);
      to_pulse <= 1'b0;
    end else begin
      to_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            state <= ST_GRANT;
            gnt_o <= win_gnt;
            last  <= win_idx;
          end
        end
        ST_GRANT: begin
          if (!mux_cyc) begin
            state <= ST_IDLE;
            gnt_o <= '0;
          end else if (wd_fire) begin
            state    <= ST_ABORT;
            to_pulse <= 1'b1;
          end
        end
        ST_ABORT: begin
          if (!mux_cyc) begin
            state <= ST_IDLE;
            gnt_o <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

  // Watchdog counts consecutive unanswered strobe cycles while granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (!in_grant || !s_stb_o || slv_resp) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

endmodule
